fir_mac_ci: RTL and testbench



---
 rtl/fir_mac_ci_pkg.sv | 25 ++
 rtl/fir_mac_ci_if.sv | 20 ++
 rtl/fir_mac_ci_history.sv | 47 ++++
 rtl/fir_mac_ci.sv | 151 +++++++++++++++
 tb/tb_fir_mac_ci.sv | 207 ++++++++++++++++++++
 5 files changed

// File: rtl/fir_mac_ci_pkg.sv
// Shared types and constants for the FIR multiply-accumulate custom instruction.
package fir_ci_pkg;

  typedef enum logic [1:0] {
    OP_LOAD_COEF = 2'd0,
    OP_PUSH      = 2'd1,
    OP_CLEAR     = 2'd2,
    OP_READ_COEF = 2'd3
  } op_e;

  typedef enum logic [1:0] {
    IDLE,
    MAC,
    OUT
  } state_e;

  localparam int SAMPLE_W_DEF  = 16;
  localparam int ACC_W_DEF     = 40;
  localparam int FRAC_BITS_DEF = 15;

  // Q15 output range
  localparam int SAT_MAX = 32767;
  localparam int SAT_MIN = -32768;

endpackage

// File: rtl/fir_mac_ci_if.sv
// Custom-instruction bus between the Nios II issue logic and the FIR MAC unit.
interface fir_mac_ci_if;
  logic        clk_en;
  logic        start;
  logic [1:0]  n;
  logic [31:0] dataa;
  logic [31:0] datab;
  logic [31:0] result;
  logic        done;

  modport master (
    output clk_en, start, n, dataa, datab,
    input  result, done
  );

  modport slave (
    input  clk_en, start, n, dataa, datab,
    output result, done
  );
endinterface

// File: rtl/fir_mac_ci_history.sv
// TAPS-deep sample history: shift-in at tap 0, synchronous clear, indexed read.
module fir_sample_history #(
  parameter int TAPS     = 32,
  parameter int SAMPLE_W = 16,
  parameter int IDX_W    = $clog2(TAPS)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                shift_i,
  input  logic                clear_i,
  input  logic [SAMPLE_W-1:0] din_i,
  input  logic [IDX_W-1:0]    rd_idx_i,
  output logic [SAMPLE_W-1:0] rd_data_o
);

  logic [SAMPLE_W-1:0] taps_w [TAPS];

  genvar gi;
  generate
    for (gi = 0; gi < TAPS; gi++) begin : g_tap
      logic [SAMPLE_W-1:0] tap_q;
      logic [SAMPLE_W-1:0] shift_src;

      if (gi == 0) begin : g_head
        assign shift_src = din_i;
      end else begin : g_body
        assign shift_src = taps_w[gi-1];
      end

      // clear wins over shift so CLEAR_HIST is never mixed with a push
      always_ff @(posedge clk) begin
        if (reset) begin
          tap_q <= '0;
        end else if (clear_i) begin
          tap_q <= '0;
        end else if (shift_i) begin
          tap_q <= shift_src;
        end
      end

      assign taps_w[gi] = tap_q;
    end
  endgenerate

  assign rd_data_o = taps_w[rd_idx_i];

endmodule

// File: rtl/fir_mac_ci.sv
// Nios II multicycle custom instruction: FIR MAC over a TAPS-deep history with Q15 saturation.
module fir_mac_ci
  import fir_ci_pkg::*;
#(
  parameter int TAPS      = 32,
  parameter int SAMPLE_W  = SAMPLE_W_DEF,
  parameter int ACC_W     = ACC_W_DEF,
  parameter int FRAC_BITS = FRAC_BITS_DEF
) (
  input logic        clk,
  input logic        reset,
  fir_mac_ci_if.slave bus
);

  localparam int IDX_W = $clog2(TAPS);
  localparam logic [IDX_W-1:0] LAST_K = IDX_W'(TAPS - 1);
  localparam logic signed [ACC_W-1:0] SAT_HI = ACC_W'(SAT_MAX);
  localparam logic signed [ACC_W-1:0] SAT_LO = ACC_W'(SAT_MIN);

  state_e                     state_q;
  logic                       done_q;
  logic [31:0]                result_q;
  logic signed [ACC_W-1:0]    acc_q;
  logic [IDX_W-1:0]           k_q;
  logic [SAMPLE_W-1:0]        coef_q [TAPS];

  op_e                        op;
  logic [IDX_W-1:0]           idx;
  logic                       issue;
  logic                       coef_we;
  logic                       hist_shift;
  logic                       hist_clear;
  logic [SAMPLE_W-1:0]        hist_rd;
  logic signed [SAMPLE_W-1:0] coef_k;
  logic signed [SAMPLE_W-1:0] hist_k;
  logic signed [2*SAMPLE_W-1:0] prod;
  logic signed [ACC_W-1:0]    acc_d;
  logic signed [ACC_W-1:0]    shifted;
  logic [SAMPLE_W-1:0]        sat;
  logic [31:0]                result_d;
  logic [SAMPLE_W-1:0]        coef_sel;
  logic                       unused_bits;

  assign op         = op_e'(bus.n);
  assign idx        = bus.datab[IDX_W-1:0];
  assign issue      = bus.clk_en && bus.start && (state_q == IDLE);
  assign coef_we    = issue && (op == OP_LOAD_COEF);
  assign hist_shift = issue && (op == OP_PUSH);
  assign hist_clear = issue && (op == OP_CLEAR);
  assign coef_sel   = coef_q[idx];
  assign unused_bits = ^{bus.dataa[31:SAMPLE_W], bus.datab[31:IDX_W]};

  fir_sample_history #(
    .TAPS     (TAPS),
    .SAMPLE_W (SAMPLE_W),
    .IDX_W    (IDX_W)
  ) u_hist (
    .clk       (clk),
    .reset     (reset),
    .shift_i   (hist_shift),
    .clear_i   (hist_clear),
    .din_i     (bus.dataa[SAMPLE_W-1:0]),
    .rd_idx_i  (k_q),
    .rd_data_o (hist_rd)
  );

  assign coef_k = coef_q[k_q];
  assign hist_k = hist_rd;

  always_comb begin
    prod     = coef_k * hist_k;
    acc_d    = acc_q + {{(ACC_W-2*SAMPLE_W){prod[2*SAMPLE_W-1]}}, prod};
    shifted  = acc_d >>> FRAC_BITS;
    if (shifted > SAT_HI) begin
      sat = SAMPLE_W'(SAT_MAX);
    end else if (shifted < SAT_LO) begin
      sat = SAMPLE_W'(SAT_MIN);
    end else begin
      sat = shifted[SAMPLE_W-1:0];
    end
    result_d = {{(32-SAMPLE_W){sat[SAMPLE_W-1]}}, sat};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < TAPS; i++) begin
        coef_q[i] <= '0;
      end
    end else if (coef_we) begin
      coef_q[idx] <= bus.dataa[SAMPLE_W-1:0];
    end
  end

  // The final product is folded in on the MAC->OUT edge, so done is presented while in OUT.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      done_q   <= 1'b0;
      result_q <= '0;
      acc_q    <= '0;
      k_q      <= '0;
    end else if (bus.clk_en) begin
      done_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (bus.start) begin
            unique case (op)
              OP_LOAD_COEF: begin
                result_q <= '0;
                done_q   <= 1'b1;
              end
              OP_READ_COEF: begin
                result_q <= {{(32-SAMPLE_W){coef_sel[SAMPLE_W-1]}}, coef_sel};
                done_q   <= 1'b1;
              end
              OP_CLEAR: begin
                result_q <= '0;
                done_q   <= 1'b1;
              end
              OP_PUSH: begin
                acc_q   <= '0;
                k_q     <= '0;
                state_q <= MAC;
              end
              default: state_q <= IDLE;
            endcase
          end
        end
        MAC: begin
          acc_q <= acc_d;
          k_q   <= k_q + IDX_W'(1);
          if (k_q == LAST_K) begin
            result_q <= result_d;
            done_q   <= 1'b1;
            state_q  <= OUT;
          end
        end
        OUT: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign bus.result = result_q;
  assign bus.done   = done_q;

endmodule

// File: tb/tb_fir_mac_ci.sv
// Directed scoreboard bench for fir_mac_ci: stimulus queues expectations, a monitor checks each done.
module tb_fir_mac_ci;
  import fir_ci_pkg::*;

  logic clk = 1'b0;
  logic reset;
  fir_mac_ci_if bus();

  fir_mac_ci dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] res;
    int          lat;
    int          issue_cyc;
    string       name;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;
  logic en_last  = 1'b0;

  always @(posedge clk) begin
    cyc     <= cyc + 1;
    en_last <= bus.clk_en;
  end

  // A done pulse is new only if the edge that produced it was enabled.
  always @(negedge clk) begin : monitor
    exp_t e;
    if (!reset && bus.done && en_last) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_done: result=%h at cycle %0d, required no done", bus.result, cyc);
      end else begin
        e = exp_q.pop_front();
        n_checks++;
        if (bus.result !== e.res) begin
          n_fail++;
          $display("FAIL %s result: got %h, required %h", e.name, bus.result, e.res);
        end
        n_checks++;
        if (cyc - e.issue_cyc != e.lat) begin
          n_fail++;
          $display("FAIL %s latency: got %0d, required %0d", e.name, cyc - e.issue_cyc, e.lat);
        end
        $display("txn %-10s result=%h latency=%0d", e.name, bus.result, cyc - e.issue_cyc);
      end
    end
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h", nm, act, req);
    end else begin
      $display("chk %-10s value=%h", nm, act);
    end
  endtask

  // Called at #1 after a posedge; leaves start low one cycle later.
  task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] exp_res, input int exp_lat, input string nm);
    bus.start = 1'b1;
    bus.n     = op;
    bus.dataa = a;
    bus.datab = b;
    exp_q.push_back('{exp_res, exp_lat, cyc, nm});
    @(posedge clk);
    #1;
    bus.start = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int t = 0;
    while (exp_q.size() != 0 && t < budget) begin
      @(posedge clk);
      #1;
      t++;
    end
    if (exp_q.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL timeout: %0d instructions pending after %0d cycles, required 0", exp_q.size(), budget);
      exp_q.delete();
    end
  endtask

  task automatic load(input int i, input logic [15:0] v);
    issue(OP_LOAD_COEF, {16'h0, v}, 32'(i), 32'h0, 1, "load");
    wait_idle(10);
  endtask

  task automatic push(input int s, input int r);
    issue(OP_PUSH, 32'(s), 32'h0, 32'(r), 33, "push");
    wait_idle(60);
  endtask

  task automatic clear_hist();
    issue(OP_CLEAR, 32'h0, 32'h0, 32'h0, 1, "clear");
    wait_idle(10);
  endtask

  task automatic step(input int c);
    repeat (c) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset      = 1'b1;
    bus.clk_en = 1'b1;
    bus.start  = 1'b0;
    bus.n      = 2'd0;
    bus.dataa  = 32'h0;
    bus.datab  = 32'h0;
    step(2);
    reset = 1'b0;
    check("rst_done", {31'h0, bus.done}, 32'h0);
    check("rst_result", bus.result, 32'h0);

    // Basic MAC: 1000 * 0x7FFF >> 15 = 999
    load(0, 16'h7FFF);
    push(1000, 999);

    // Averaging over four taps of 0.5
    clear_hist();
    for (int i = 0; i < 4; i++) load(i, 16'h4000);
    push(100, 50);
    push(200, 150);
    push(300, 300);
    push(400, 500);

    // Saturation both ways; sign crosses zero at the 16th negative push
    clear_hist();
    for (int i = 0; i < 32; i++) load(i, 16'h7FFF);
    for (int i = 1; i <= 32; i++) push(32767, (i == 1) ? 32766 : 32767);
    for (int j = 1; j <= 32; j++) push(-32768, (j <= 15) ? 32767 : (j == 16) ? -16 : -32768);

    // Delay/ordering through the last tap only
    clear_hist();
    for (int i = 0; i < 32; i++) load(i, (i == 31) ? 16'h4000 : 16'h0000);
    for (int p = 1; p <= 33; p++) push(2 * p, (p < 32) ? 0 : p - 31);
    clear_hist();
    push(8, 0);

    // Stall: 5 disabled cycles during MAC push done to cycle 38
    issue(OP_PUSH, 32'd10, 32'h0, 32'h0, 38, "push_stall");
    step(3);
    bus.clk_en = 1'b0;
    step(5);
    bus.clk_en = 1'b1;
    wait_idle(60);

    // start while busy must be ignored (would otherwise overwrite coef[31])
    issue(OP_PUSH, 32'd12, 32'h0, 32'h0, 33, "push_busy");
    step(9);
    bus.start = 1'b1;
    bus.n     = OP_LOAD_COEF;
    bus.dataa = 32'h0000_1234;
    bus.datab = 32'd31;
    step(1);
    bus.start = 1'b0;
    wait_idle(60);
    step(5);
    issue(OP_READ_COEF, 32'h0, 32'd31, 32'h0000_4000, 1, "read31");
    wait_idle(10);

    // Reset mid-push: no done, result and coefficients cleared
    issue(OP_PUSH, 32'd14, 32'h0, 32'h0, 33, "push_abort");
    step(9);
    reset = 1'b1;
    step(1);
    reset = 1'b0;
    exp_q.delete();
    step(40);
    check("abort_result", bus.result, 32'h0);
    issue(OP_READ_COEF, 32'h0, 32'd31, 32'h0, 1, "read_rst");
    wait_idle(10);

    // Index wrap: 37 mod 32 = 5
    load(37, 16'h8001);
    issue(OP_READ_COEF, 32'h0, 32'd5, 32'hFFFF_8001, 1, "read5");
    wait_idle(10);

    step(5);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
